// File: rtl/dmem_line_pkg.sv
// dmem_line_pkg: shared FSM state type and default line geometry for dmem_line_ctrl.
package dmem_line_pkg;

    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} line_state_t;

    localparam int LINE_WORDS_DEFAULT = 4;

endpackage

// File: rtl/dmem_line_ctrl.sv
// dmem_line_ctrl: sequences whole-line writebacks and refills as per-word accesses to data_mem.
// Optional macro DMEM_LINE_CRITICAL_WORD_FIRST_EN adds req_word and starts refills at that word.
module dmem_line_ctrl
    import dmem_line_pkg::*;
#(
    parameter int n          = 32,
    parameter int dmem_size  = 6,
    parameter int LINE_WORDS = LINE_WORDS_DEFAULT
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    req_valid,
    output logic                                    req_ready,
    input  logic                                    req_write,
    input  logic [dmem_size-$clog2(LINE_WORDS)-1:0] req_line,
`ifdef DMEM_LINE_CRITICAL_WORD_FIRST_EN
    input  logic [$clog2(LINE_WORDS)-1:0]           req_word,
`endif
    input  logic [LINE_WORDS*n-1:0]                 wb_line,
    output logic [LINE_WORDS*n-1:0]                 fill_line,
    output logic                                    done,
    output logic [dmem_size-1:0]                    address,
    output logic [n-1:0]                            dmem_wdata,
    output logic                                    load_control,
    output logic                                    store_control,
    input  logic [n-1:0]                            dmem_rdata
);

    localparam int CW     = $clog2(LINE_WORDS);
    localparam int LINE_W = dmem_size - CW;
    localparam logic [CW:0] LAST_C = (CW+1)'(LINE_WORDS - 1);
    localparam logic [CW:0] DRAIN_C = (CW+1)'(LINE_WORDS);

    line_state_t                     state_q;
    logic [CW:0]                     cnt_q;
    logic [LINE_W-1:0]               line_q;
    logic [LINE_WORDS-1:0][n-1:0]    wb_q;
    logic [LINE_WORDS-1:0][n-1:0]    fill_q;
    logic [CW-1:0]                   start;
    logic [CW-1:0]                   widx;
    logic [CW-1:0]                   ridx;
    logic                            issue;

`ifdef DMEM_LINE_CRITICAL_WORD_FIRST_EN
    logic [CW-1:0] start_q;

    // first word of the refill, zero for writebacks so they always run in order
    always_ff @(posedge clk or posedge reset)
        if (reset) start_q <= '0;
        else if (state_q == IDLE && req_valid) start_q <= req_write ? '0 : req_word;

    assign start = start_q;
`else
    assign start = '0;
`endif

    // word addressed this cycle wraps within the line; the word returning now was issued one cycle earlier
    assign widx = cnt_q[CW-1:0] + start;
    assign ridx = widx - 1'b1;
    // cnt reaching LINE_WORDS marks the drain cycle, where no load is issued
    assign issue = state_q == READ && !cnt_q[CW];

    assign req_ready     = state_q == IDLE && !reset;
    assign done          = state_q == DONE;
    assign load_control  = issue;
    assign store_control = state_q == WRITE;
    assign address       = (issue || store_control) ? {line_q, widx} : '0;
    assign dmem_wdata    = store_control ? wb_q[widx] : '0;
    assign fill_line     = fill_q;

    // line-transfer FSM: accept, issue one word per cycle, drain the last read, pulse done
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            line_q  <= '0;
            wb_q    <= '0;
            fill_q  <= '0;
        end else begin
            case (state_q)
                IDLE: if (req_valid) begin
                    state_q <= req_write ? WRITE : READ;
                    cnt_q   <= '0;
                    line_q  <= req_line;
                    wb_q    <= wb_line;
                end
                WRITE: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_C) state_q <= DONE;
                end
                READ: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q != '0) fill_q[ridx] <= dmem_rdata;
                    if (cnt_q == DRAIN_C) state_q <= DONE;
                end
                DONE: state_q <= IDLE;
            endcase
        end
    end

endmodule
